// File: rtl/divmul_pkg.sv
// Shared definitions for the divide/multiply datapath.
//   QW/DW/RW         : quotient, divisor/remainder and result widths
//   state_e          : sequencing states of the shift-add multiplier
//   DIVD_MIN/MAX     : legal 8-bit dividend range, used for fits8
package divmul_pkg;

    localparam int QW = 8;
    localparam int DW = 4;
    localparam int RW = QW + DW;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic signed [RW-1:0] DIVD_MIN = RW'(-128);
    localparam logic signed [RW-1:0] DIVD_MAX = RW'(127);

endpackage

// File: rtl/seq_recon_mul_8x4_abs_sign_split.sv
// Combinational magnitude/sign split of a two's-complement operand.
//   val_i  : signed operand, W bits
//   mag_o  : unsigned magnitude, W bits (the most negative value maps to 2^(W-1))
//   sign_o : 1 when val_i is negative
module abs_sign_split #(
    parameter int W = 8
) (
    input  logic [W-1:0] val_i,
    output logic [W-1:0] mag_o,
    output logic         sign_o
);

    assign sign_o = val_i[W-1];
    assign mag_o  = sign_o ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/seq_recon_mul_8x4.sv
// Sequential signed shift-add multiplier: result = quotient*divisor + remainder.
// Rebuilds a dividend from the outputs of the 8-by-4 signed divider.
//   clk, rst_n  : clock, async active-low reset
//   start       : request, accepted in IDLE or DONE
//   quotient    : signed multiplicand (QW)
//   divisor     : signed multiplier (DW)
//   remainder   : unsigned addend (DW)
//   busy        : operation in progress (MUL, FIX)
//   done        : one-cycle pulse, result valid
//   result      : signed result (RW), held until the next done
//   fits8       : result is a legal 8-bit dividend
//
// state | meaning
// IDLE  | waiting for start
// MUL   | DW shift-add steps on magnitudes
// FIX   | apply sign, add remainder, register result
// DONE  | done pulse; may accept the next start
module seq_recon_mul_8x4
    import divmul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [QW-1:0] quotient,
    input  logic signed [DW-1:0] divisor,
    input  logic        [DW-1:0] remainder,
    output logic                 busy,
    output logic                 done,
    output logic signed [RW-1:0] result,
    output logic                 fits8
);

    state_e                state_q, state_d;
    logic [RW-1:0]         mcand_q, mcand_d;
    logic [DW-1:0]         mplier_q, mplier_d;
    logic [RW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic [DW-1:0]         rem_q, rem_d;
    logic signed [RW-1:0]  result_q, result_d;
    logic                  fits8_q, fits8_d;

    logic [QW-1:0]         q_mag;
    logic                  q_sign;
    logic [DW-1:0]         d_mag;
    logic                  d_sign;
    logic                  accept;
    logic [RW-1:0]         fixed;
    logic signed [RW-1:0]  sum;

    abs_sign_split #(.W(QW)) u_abs_q (
        .val_i  (quotient),
        .mag_o  (q_mag),
        .sign_o (q_sign)
    );

    abs_sign_split #(.W(DW)) u_abs_d (
        .val_i  (divisor),
        .mag_o  (d_mag),
        .sign_o (d_sign)
    );

    // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rem_d    = rem_q;
        result_d = result_q;
        fits8_d  = fits8_q;
        busy     = 1'b0;
        done     = 1'b0;
        fixed    = neg_q ? (~acc_q + RW'(1)) : acc_q;
        sum      = $signed(fixed + {{QW{1'b0}}, rem_q});

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            MUL: begin
                busy = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy     = 1'b1;
                result_d = sum;
                fits8_d  = (sum >= DIVD_MIN) && (sum <= DIVD_MAX);
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            mcand_d  = {{DW{1'b0}}, q_mag};
            mplier_d = d_mag;
            neg_d    = q_sign ^ d_sign;
            rem_d    = remainder;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rem_q    <= '0;
            result_q <= '0;
            fits8_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            fits8_q  <= fits8_d;
        end
    end

    assign result = result_q;
    assign fits8  = fits8_q;

endmodule
